// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the sequence-detector bench:
// FSM state encoding and the default word width.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer_word_buf.sv
// One-deep holding register that parks the next word while the current one
// is still being shifted out.
module word_buf
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             unload,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // load is only issued while empty and unload only while full, so the two
    // strobes never meet on the same edge.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (unload) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input, one-word holding buffer
// for gapless back-to-back words, and a stall input that freezes the stream.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic             accept;
    logic             buf_load;
    logic             buf_unload;
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;
    logic [WIDTH-1:0] sreg_shifted;

    word_buf #(
        .WIDTH (WIDTH)
    ) u_word_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_data (in_data),
        .unload    (buf_unload),
        .full      (buf_full),
        .data      (buf_data)
    );

    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (stall || cnt_q != LAST_CNT) begin
                    if (!stall) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + 1'b1;
                    end
                    buf_load = accept;
                end else if (buf_full) begin
                    // Last bit: the buffered word follows with no idle bit.
                    sreg_d     = buf_data;
                    cnt_d      = '0;
                    buf_unload = 1'b1;
                end else if (accept) begin
                    sreg_d = in_data;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_valid = (state_q == SHIFT);
    assign x       = x_valid & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign busy    = (state_q == SHIFT) | buf_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: table of word streams with expected serial
// bit sequences, plus hand-written reset sequences.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       stall;
    logic       sel;

    logic in_ready_h, x_h, x_valid_h, busy_h;
    logic in_ready_l, x_l, x_valid_l, busy_l;
    logic in_ready_m, x_m, x_valid_m, busy_m;

    int checks = 0;
    int errors = 0;

    logic ready_q[$];

    typedef struct {
        int          sel;
        int          n;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        int          stall_at;
        int          stall_len;
        logic [31:0] exp_bits;
    } vec_t;

    vec_t vecs[8];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid & ~sel),
        .in_ready (in_ready_h),
        .stall    (stall),
        .x        (x_h),
        .x_valid  (x_valid_h),
        .busy     (busy_h)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid & sel),
        .in_ready (in_ready_l),
        .stall    (stall),
        .x        (x_l),
        .x_valid  (x_valid_l),
        .busy     (busy_l)
    );

    assign in_ready_m = sel ? in_ready_l : in_ready_h;
    assign x_m        = sel ? x_l        : x_h;
    assign x_valid_m  = sel ? x_valid_l  : x_valid_h;
    assign busy_m     = sel ? busy_l     : busy_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Offer the words of one vector continuously, apply its stall window and
    // collect every x bit while x_valid is high.
    task automatic run_vec(input int vi, input vec_t v);
        logic [7:0]  w[3];
        logic [31:0] got;
        int          idx;
        int          got_n;
        bit          started;
        bit          done;
        bit          acc;
        w[0] = v.w0;
        w[1] = v.w1;
        w[2] = v.w2;
        sel = v.sel[0];
        ready_q.delete();
        idx = 0;
        got_n = 0;
        got = '0;
        started = 1'b0;
        done = 1'b0;
        in_data = w[0];
        in_valid = 1'b1;
        for (int k = 1; k <= 200 && !done; k++) begin
            acc = in_valid && in_ready_m;
            @(posedge clk);
            #1;
            ready_q.push_back(in_ready_m);
            if (acc) begin
                idx++;
                if (idx < v.n) begin
                    in_data = w[idx];
                end else begin
                    in_valid = 1'b0;
                    in_data = ~in_data;
                end
            end
            if (k == v.stall_at) stall = 1'b1;
            if (k == v.stall_at + v.stall_len) stall = 1'b0;
            if (x_valid_m) begin
                got = {got[30:0], x_m};
                got_n++;
                started = 1'b1;
            end else if (started) begin
                done = 1'b1;
            end
        end
        stall = 1'b0;
        in_valid = 1'b0;
        $display("vec %0d: %0d bits collected, pattern %0h", vi, got_n, got);
        check($sformatf("vec%0d_finished", vi), {31'd0, done}, 32'd1);
        check($sformatf("vec%0d_bit_count", vi), got_n, v.n * 8 + v.stall_len);
        check($sformatf("vec%0d_bits", vi), got, v.exp_bits);
        check($sformatf("vec%0d_idle_x", vi), {31'd0, x_m}, 32'd0);
        check($sformatf("vec%0d_idle_busy", vi), {31'd0, busy_m}, 32'd0);
        check($sformatf("vec%0d_idle_ready", vi), {31'd0, in_ready_m}, 32'd1);
    endtask

    initial begin
        int bad;
        vecs[0] = '{0, 1, 8'hB2, 8'h00, 8'h00, 0, 0, 32'hB2};
        vecs[1] = '{0, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, 32'hA53C};
        vecs[2] = '{0, 1, 8'hF0, 8'h00, 8'h00, 4, 2, 32'h3F0};
        vecs[3] = '{0, 3, 8'h01, 8'h02, 8'h03, 0, 0, 32'h010203};
        vecs[4] = '{0, 2, 8'hA5, 8'h3C, 8'h00, 2, 3, 32'h4253C};
        vecs[5] = '{1, 1, 8'hB2, 8'h00, 8'h00, 0, 0, 32'h4D};
        vecs[6] = '{1, 1, 8'h01, 8'h00, 8'h00, 0, 0, 32'h80};
        vecs[7] = '{1, 2, 8'hB2, 8'h01, 8'h00, 0, 0, 32'h4D80};

        rst = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        stall = 1'b0;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_x", {31'd0, x_m}, 32'd0);
        check("reset_x_valid", {31'd0, x_valid_m}, 32'd0);
        check("reset_busy", {31'd0, busy_m}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready_m}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            if (i == 3) begin
                check("ready_after_1st_accept", {31'd0, ready_q[0]}, 32'd1);
                check("ready_after_2nd_accept", {31'd0, ready_q[1]}, 32'd0);
                check("ready_before_last_bit", {31'd0, ready_q[7]}, 32'd0);
                check("ready_after_last_bit", {31'd0, ready_q[8]}, 32'd1);
                check("ready_after_3rd_accept", {31'd0, ready_q[9]}, 32'd0);
            end
            repeat (2) @(posedge clk);
            #1;
        end

        // Asynchronous reset while bit 4 of 8'hFF is on x.
        sel = 1'b0;
        in_data = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_x_valid", {31'd0, x_valid_m}, 32'd1);
        check("pre_reset_x", {31'd0, x_m}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_x", {31'd0, x_m}, 32'd0);
        check("async_reset_x_valid", {31'd0, x_valid_m}, 32'd0);
        check("async_reset_busy", {31'd0, busy_m}, 32'd0);
        check("async_reset_in_ready", {31'd0, in_ready_m}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (x_valid_m || busy_m || x_m) bad++;
        end
        check("post_reset_no_residual", bad, 0);
        run_vec(8, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
